mem_access_unit: RTL

- MEM stage of the 5-stage RV32I pipeline, directly downstream of the EX/MEM pipeline register.
- Consumes the registered ALU result (address), rs2 data, the memory-select flag and the 4-bit read/write code.
- Drives a req/ack data-memory bus with byte enables, and stalls the pipeline until the access completes.
- Returns aligned, sign/zero-extended load data toward the MEM/WB register; flags misaligned accesses and bus timeouts.

---
 rtl/mem_pkg.sv | 51 +++++
 rtl/load_align_ext.sv | 28 ++
 rtl/mem_access_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM stage.
//   - funct3 encodings for loads/stores
//   - memory FSM state enum
//   - bit index of is_store inside the {is_store, funct3} code
//   - helpers for operation legality and store lane generation
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int IS_STORE_BIT = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Stores only exist in B/H/W widths; loads add the unsigned variants.
    function automatic logic is_legal_op(input logic [3:0] rw);
        logic [2:0] f3;
        f3 = rw[2:0];
        if (rw[IS_STORE_BIT]) begin
            is_legal_op = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            is_legal_op = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                          (f3 == F3_BU) || (f3 == F3_HU);
        end
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    store_be = 4'b0001 << off;
            F3_H:    store_be = off[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    // Data is replicated across lanes so the byte enables alone select the target.
    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_B:    store_wdata = {4{d[7:0]}};
            F3_H:    store_wdata = {2{d[15:0]}};
            default: store_wdata = d;
        endcase
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// load_align_ext: combinational load lane extraction and extension.
//   rdata    in  32  raw word from the data bus
//   offset   in  2   byte offset of the access within the word
//   funct3   in  3   load width/signedness
//   ext_data out 32  aligned, sign/zero-extended result
module load_align_ext
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] ext_data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            F3_B:    ext_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   ext_data = {24'd0, shifted[7:0]};
            F3_H:    ext_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   ext_data = {16'd0, shifted[15:0]};
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage of the RV32I pipeline.
//   Inputs : IN_DATAMEMSEL, IN_READ_WRITE {is_store,funct3}, IN_ALU_RESULT, IN_DATA2,
//            MEM_RDATA, MEM_ACK
//   Bus    : MEM_REQ, MEM_WE, MEM_ADDR (word aligned), MEM_BE, MEM_WDATA (registered)
//   Pipe   : STALL (combinational), LOAD_DATA, LOAD_VALID, MISALIGNED, BUS_ERROR
//   Debug  : DBG_STATE exposes the FSM state.
// Handshake: MEM_REQ rises when an access launches and stays high with all bus
// outputs stable until the cycle MEM_ACK is sampled high (or the timeout fires);
// MEM_ACK is a single-cycle pulse and is ignored outside BUSY.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IN_DATAMEMSEL,
    input  logic [3:0]        IN_READ_WRITE,
    input  logic [31:0]       IN_ALU_RESULT,
    input  logic [31:0]       IN_DATA2,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [3:0]        MEM_BE,
    output logic [31:0]       MEM_WDATA,
    input  logic [31:0]       MEM_RDATA,
    input  logic              MEM_ACK,
    output logic              STALL,
    output logic [31:0]       LOAD_DATA,
    output logic              LOAD_VALID,
    output logic              MISALIGNED,
    output logic              BUS_ERROR,
    output state_e            DBG_STATE
);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        f3_q, f3_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              load_valid_q, load_valid_d;
    logic              bus_error_q, bus_error_d;
    logic              stall_c;
    logic              launch;
    logic [31:0]       ext_data;

    wire [2:0] f3_in    = IN_READ_WRITE[2:0];
    wire       store_in = IN_READ_WRITE[IS_STORE_BIT];
    wire [1:0] off_in   = IN_ALU_RESULT[1:0];

    assign MISALIGNED = IN_DATAMEMSEL &
        ((((f3_in == F3_H) || (f3_in == F3_HU)) & off_in[0]) |
         ((f3_in == F3_W) & (off_in != 2'b00)));

    assign launch = IN_DATAMEMSEL & is_legal_op(IN_READ_WRITE) & ~MISALIGNED;

    // Extraction works from the offset/width captured at launch, not the live inputs.
    load_align_ext u_align (
        .rdata    (MEM_RDATA),
        .offset   (off_q),
        .funct3   (f3_q),
        .ext_data (ext_data)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        off_d        = off_q;
        f3_d         = f3_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        bus_error_d  = 1'b0;
        stall_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    stall_c = 1'b1;
                    state_d = S_BUSY;
                    cnt_d   = 8'd0;
                    req_d   = 1'b1;
                    we_d    = store_in;
                    addr_d  = ADDR_W'({IN_ALU_RESULT[31:2], 2'b00});
                    be_d    = store_in ? store_be(f3_in, off_in) : 4'b1111;
                    wdata_d = store_in ? store_wdata(f3_in, IN_DATA2) : IN_DATA2;
                    off_d   = off_in;
                    f3_d    = f3_in;
                end
            end
            S_BUSY: begin
                stall_c = 1'b1;
                // An ack in the timeout cycle takes priority over the error.
                if (MEM_ACK) begin
                    state_d = S_DONE;
                    cnt_d   = 8'd0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    if (!we_q) begin
                        load_data_d  = ext_data;
                        load_valid_d = 1'b1;
                    end
                end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = S_DONE;
                    cnt_d       = 8'd0;
                    req_d       = 1'b0;
                    we_d        = 1'b0;
                    bus_error_d = 1'b1;
                    load_data_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                // One unstalled cycle lets EX/MEM advance so the op is not relaunched.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= 4'd0;
            wdata_q      <= 32'd0;
            off_q        <= 2'd0;
            f3_q         <= 3'd0;
            load_data_q  <= 32'd0;
            load_valid_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            off_q        <= off_d;
            f3_q         <= f3_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            bus_error_q  <= bus_error_d;
        end
    end

    // Gating with RST_N keeps STALL low while reset is held even if a memory op is presented.
    assign STALL      = stall_c & RST_N;
    assign MEM_REQ    = req_q;
    assign MEM_WE     = we_q;
    assign MEM_ADDR   = addr_q;
    assign MEM_BE     = be_q;
    assign MEM_WDATA  = wdata_q;
    assign LOAD_DATA  = load_data_q;
    assign LOAD_VALID = load_valid_q;
    assign BUS_ERROR  = bus_error_q;
    assign DBG_STATE  = state_q;

endmodule
